// File: rtl/noc_e1of2_tx_if.sv
// Bundles the two handshakes of the injector: a clocked valid/ready packet port
// and the asynchronous dual-rail (e1of2) output with its enable return wire.
//
// Handshake semantics:
//   in_valid/in_ready : a packet moves on a rising CLK edge where both are 1.
//                       in_ready does not depend on in_valid.
//   tx_d/tx_e         : four-phase. The receiver raises tx_e when it is ready. The
//                       sender drives a full codeword on tx_d. The receiver drops
//                       tx_e to acknowledge. The sender returns tx_d to all-zero
//                       (neutral), and the receiver raises tx_e again.
interface noc_e1of2_tx_if #(
  parameter int WIDTH = 11
);
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic [2*WIDTH-1:0] tx_d;
  logic               tx_e;

  // Injector side
  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_e,
    output in_ready,
    output tx_d
  );

  // Producer / receiver side
  modport master (
    output in_valid,
    output in_data,
    output tx_e,
    input  in_ready,
    input  tx_d
  );
endinterface

// File: rtl/noc_e1of2_tx.sv
// Synchronous-to-asynchronous packet injector. Packets are buffered in a small
// FIFO and leave as e1of2 dual-rail words under a four-phase enable handshake.
// tx_d always comes straight from a register, so the rails never glitch.
module noc_e1of2_tx #(
  parameter int WIDTH       = 11,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  noc_e1of2_tx_if.slave        io,
  output logic                 busy,
  output logic [15:0]          sent_count,
  output logic [1:0]           o_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_NEUTRAL = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2*WIDTH-1:0]     r_tx_d;
  logic [15:0]            r_sent_count;
  logic                   r_run;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_e_s;
  logic                   w_load;
  logic                   w_clear;
  logic                   w_count_inc;
  logic [WIDTH-1:0]       w_head;
  logic [2*WIDTH-1:0]     w_enc;

  // FIFO status: the extra pointer bit tells full apart from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_e_s   = r_sync[SYNC_STAGES-1];

  // r_run keeps in_ready low while reset is held and for the release edge itself.
  assign io.in_ready = r_run && !w_full;
  assign w_push      = io.in_valid && io.in_ready;

  assign io.tx_d     = r_tx_d;
  assign sent_count  = r_sent_count;
  assign busy        = !w_empty || (r_state != ST_IDLE);
  assign o_state     = r_state;

  // Run flag: sets on the first clock edge after reset is released.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  // Synchroniser chain bringing the asynchronous tx_e into the CLK domain.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], io.tx_e};
  end

  // FIFO storage. It needs no reset because the pointers qualify every read.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= io.in_data;
  end

  // FIFO pointers. A push and a pop on the same edge leave the occupancy unchanged.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Dual-rail encode of the FIFO head: rail-1 carries the bit, rail-0 its inverse.
  always_comb begin
    w_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_enc[2*i+1] = w_head[i];
      w_enc[2*i]   = ~w_head[i];
    end
  end

  // FSM next-state and control. Decisions use only the synchronised enable.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_count_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_e_s) begin
          w_load       = 1'b1;
          w_pop        = 1'b1;
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!w_e_s) begin
          w_clear      = 1'b1;
          w_count_inc  = 1'b1;
          w_next_state = ST_NEUTRAL;
        end
      end
      ST_NEUTRAL: begin
        if (w_e_s) w_next_state = ST_IDLE;
      end
      default: begin
        w_clear      = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Output rails. Reset forces neutral immediately, which drops any in-flight word.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET)      r_tx_d <= '0;
    else if (w_load)  r_tx_d <= w_enc;
    else if (w_clear) r_tx_d <= '0;
  end

  // Completed-packet counter. It wraps from 16'hFFFF to zero.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET)          r_sent_count <= '0;
    else if (w_count_inc) r_sent_count <= r_sent_count + 16'd1;
  end

endmodule

// File: tb/tb_noc_e1of2_tx.sv
// Directed and randomised bench for noc_e1of2_tx. Expected packets are queued
// when the FIFO accepts them and popped when a dual-rail word appears on tx_d.
module tb_noc_e1of2_tx;

  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          busy;
  logic [15:0]   sent_count;
  logic [1:0]    state;

  logic rx_auto = 1'b0;
  logic rx_e    = 1'b1;
  logic man_e   = 1'b1;

  noc_e1of2_tx_if #(.WIDTH(W)) bus ();

  assign bus.tx_e = rx_auto ? rx_e : man_e;

  noc_e1of2_tx #(.WIDTH(W), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .CLK        (clk),
    ._RESET     (rst_n),
    .io         (bus),
    .busy       (busy),
    .sent_count (sent_count),
    .o_state    (state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_err    = 0;
  int           n_sent_exp = 0;
  int           n_rx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = b[i];
      r[2*i]   = !b[i];
    end
    return r;
  endfunction

  function automatic logic complete(input logic [2*W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < W; i++) ok = ok && (d[2*i+1] ^ d[2*i]);
    return ok;
  endfunction

  function automatic logic [W-1:0] dec(input logic [2*W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[2*i+1];
    return r;
  endfunction

  // No bit may ever have both rails high.
  always @(negedge clk) begin
    logic both;
    both = 1'b0;
    for (int i = 0; i < W; i++) both = both | (bus.tx_d[2*i+1] & bus.tx_d[2*i]);
    chk("dual_rail_exclusive", 32'(both), 32'(0));
  end

  // Responsive receiver model with random acknowledge delays.
  initial begin : rx_model
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int n;
    forever begin
      @(negedge clk);
      if (rx_auto && complete(bus.tx_d)) begin
        got = dec(bus.tx_d);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_word", 32'(got), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          chk("rx_word", 32'(got), 32'(exp));
        end
        n_rx++;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        rx_e = 1'b0;
        n = 0;
        while (bus.tx_d != '0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("rx_neutral_timeout", 32'(n >= 50), 32'(0));
        repeat ($urandom_range(0, 7)) @(negedge clk);
        rx_e = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n >= 400), 32'(0));
    if (n < 400) begin
      @(posedge clk);
      exp_q.push_back(d);
      n_sent_exp++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n_sent_exp = 0;
    repeat (3) @(negedge clk);
  endtask

  // Global time limit.
  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main_seq
    logic [W-1:0]   pkt;
    logic [W-1:0]   exp;
    int             n;

    // 1: reset held with enable high and a valid packet offered
    rst_n        = 1'b0;
    man_e        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 11'h7FF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_d",       32'(bus.tx_d),     32'(0));
    chk("rst_busy",       32'(busy),         32'(0));
    chk("rst_sent_count", 32'(sent_count),   32'(0));
    chk("rst_in_ready",   32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("post_rst_busy",     32'(busy),         32'(0));
    chk("post_rst_state",    32'(state),        32'(0));

    // 2: single packet, manual handshake, latency checks
    push_pkt(11'h5A3);
    @(negedge clk);
    chk("single_not_early", 32'(bus.tx_d), 32'(0));
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    chk("single_word_const", 32'(bus.tx_d), 32'h0026_995A);
    chk("single_word_enc",   32'(bus.tx_d), 32'(enc(exp)));
    chk("single_state_data", 32'(state),    32'(1));
    man_e = 1'b0;
    n = 0;
    while (bus.tx_d != '0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fall_to_neutral_cycles", 32'(n), 32'(3));
    chk("single_sent_count",      32'(sent_count), 32'(1));
    chk("single_busy_neutral",    32'(busy),       32'(1));
    man_e = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("single_idle_state", 32'(state), 32'(0));
    chk("single_idle_busy",  32'(busy),  32'(0));

    // 3: stall with enable low from reset, FIFO fills, then drains in order
    man_e = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push_pkt(11'(11'h100 + 11'(i * 37)));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 11'h2C5;
    repeat (4) @(negedge clk);
    chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
    chk("stall_tx_d",     32'(bus.tx_d),     32'(0));
    chk("stall_busy",     32'(busy),         32'(1));
    rx_e    = 1'b1;
    rx_auto = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_release_timeout", 32'(n >= 200), 32'(0));
    @(posedge clk);
    exp_q.push_back(11'h2C5);
    n_sent_exp++;
    #1 bus.in_valid = 1'b0;
    drain(500);
    chk("stall_sent_count", 32'(sent_count), 32'(n_sent_exp));

    // 4: random stream through the responsive receiver
    n = n_rx;
    for (int i = 0; i < 100; i++) begin
      pkt = 11'($urandom_range(0, 2047));
      push_pkt(pkt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(5000);
    chk("stream_rx_count",    32'(n_rx - n),   32'(100));
    chk("stream_sent_count",  32'(sent_count), 32'(n_sent_exp));

    // 6: reset while a word is on the rails
    rx_auto = 1'b0;
    man_e   = 1'b1;
    do_reset();
    push_pkt(11'h3E1);
    n = 0;
    while (bus.tx_d == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_data_timeout", 32'(n >= 20), 32'(0));
    exp = exp_q.pop_front();
    chk("mid_data_word", 32'(bus.tx_d), 32'(enc(exp)));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_d",       32'(bus.tx_d),   32'(0));
    chk("mid_rst_busy",       32'(busy),       32'(0));
    chk("mid_rst_sent_count", 32'(sent_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n_sent_exp = 0;
    rx_e    = 1'b1;
    rx_auto = 1'b1;
    repeat (3) @(negedge clk);
    push_pkt(11'h0A7);
    drain(500);
    chk("after_rst_sent_count", 32'(sent_count), 32'(1));

    // 5: counter wrap from 16'hFFFF
    @(negedge clk);
    force dut.r_sent_count = 16'hFFFF;
    #1;
    release dut.r_sent_count;
    push_pkt(11'h155);
    push_pkt(11'h6AA);
    drain(500);
    chk("wrap_sent_count", 32'(sent_count), 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
